dot_product_acc_8: RTL and testbench

Sequential dot-product accumulator sitting directly downstream of the team's combinational 8x8 unsigned partial-product multiplier. It consumes one 16-bit unsigned product per cycle under a valid/ready handshake and sums a programmed number of products into a wide accumulator. It then presents the sum with an overflow flag on a second valid/ready output port. The multiplier stays purely combinational; this block supplies all registering, sequencing and flow control for the multiply-accumulate path.

---
 rtl/dot_acc_pkg.sv | 20 ++
 rtl/dot_product_acc_8_if.sv | 25 ++
 rtl/dot_acc_datapath.sv | 49 ++++
 rtl/dot_product_acc_8.sv | 72 +++++++
 tb/tb_dot_product_acc_8.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot-product accumulator.
// Product width is fixed by the upstream 8x8 multiplier.
package dot_acc_pkg;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;
    localparam int PROD_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Longest job of all-ones products that cannot carry out of acc_w bits.
    function automatic int max_clean_len(input int acc_w);
        longint unsigned lim;
        lim = (64'd1 << acc_w) - 64'd1;
        return int'(lim / 64'd65535);
    endfunction
endpackage

// File: rtl/dot_product_acc_8_if.sv
// Product-in / result-out handshake bundle for dot_product_acc_8.
// master = upstream/downstream side, slave = the accumulator.
interface dot_product_acc_8_if
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/dot_acc_datapath.sv
// Accumulator, sticky carry-out flag and remaining-beat counter.
// Sequencing comes from the FSM in the top via load/beat/clear.
module dot_acc_datapath
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              beat,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic              last
);
    localparam int SW = ACC_W + 1;
    localparam int RW = LEN_W + 1;

    logic [LEN_W:0] rem;
    logic [ACC_W:0] sum;

    assign sum  = {1'b0, acc} + SW'(product);
    assign last = (rem == RW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            rem <= '0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
            rem <= '0;
        end else if (load) begin
            acc <= '0;
            ovf <= 1'b0;
            // len==0 encodes the full 2^LEN_W, hence the extra counter bit
            rem <= (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
        end else if (beat) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            rem <= rem - RW'(1);
        end
    end
endmodule

// File: rtl/dot_product_acc_8.sv
// Dot-product accumulator top: job FSM and handshake decode.
// Every output is decoded from registered state; no input reaches an output combinationally.
module dot_product_acc_8
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             clear,
    output logic             busy,
    dot_product_acc_8_if.slave bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ACCUM = ACCUM;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             load;
    logic             beat;
    logic             last;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    assign load = (state == S_IDLE)  & start         & ~clear;
    assign beat = (state == S_ACCUM) & bus.in_valid  & ~clear;

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start)             state_nxt = S_ACCUM;
                S_ACCUM: if (beat && last)      state_nxt = S_DONE;
                S_DONE:  if (bus.out_ready)     state_nxt = S_IDLE;
                default:                        state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    dot_acc_datapath #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .load    (load),
        .beat    (beat),
        .len     (len),
        .product (bus.product),
        .acc     (acc),
        .ovf     (ovf),
        .last    (last)
    );

    assign bus.in_ready  = (state == S_ACCUM);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_dot_product_acc_8.sv
// Drives a 24-bit and a 16-bit accumulator in lockstep and checks both
// against a whole-job arithmetic model of sum and carry-out.
module tb_dot_product_acc_8;
    import dot_acc_pkg::*;

    typedef logic [15:0] pq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] product = '0;
    logic        out_ready = 1'b0;
    logic        busy24, busy16;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dot_product_acc_8_if #(.ACC_W(24)) bus24 ();
    dot_product_acc_8_if #(.ACC_W(16)) bus16 ();

    assign bus24.in_valid  = in_valid;
    assign bus24.product   = product;
    assign bus24.out_ready = out_ready;
    assign bus16.in_valid  = in_valid;
    assign bus16.product   = product;
    assign bus16.out_ready = out_ready;

    dot_product_acc_8 #(.ACC_W(24), .LEN_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .clear(clear), .busy(busy24), .bus(bus24.slave)
    );
    dot_product_acc_8 #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .clear(clear), .busy(busy16), .bus(bus16.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Products are non-negative, so some step carried iff the exact total reaches 2^w.
    task automatic model(input pq_t q, input int w, output logic [63:0] s, output logic o);
        longint unsigned tot = 0;
        foreach (q[i]) tot += q[i];
        s = tot & ((64'd1 << w) - 64'd1);
        o = (tot >> w) != 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy24"},   busy24,          0);
        chk({tag, " busy16"},   busy16,          0);
        chk({tag, " rdy24"},    bus24.in_ready,  0);
        chk({tag, " vld24"},    bus24.out_valid, 0);
        chk({tag, " vld16"},    bus16.out_valid, 0);
        chk({tag, " sum24"},    bus24.out_sum,   0);
        chk({tag, " sum16"},    bus16.out_sum,   0);
        chk({tag, " ovf24"},    bus24.out_ovf,   0);
        chk({tag, " ovf16"},    bus16.out_ovf,   0);
    endtask

    task automatic run_job(input string tag, input pq_t q, input int gap_pct,
                           input bit poke, input int stall);
        logic [63:0] s24, s16;
        logic        o24, o16;
        int          n = q.size();
        model(q, 24, s24, o24);
        model(q, 16, s16, o16);
        start = 1'b1;
        len   = 8'(n);
        tick;
        start = 1'b0;
        chk({tag, " start busy"}, busy24, 1);
        chk({tag, " start rdy"},  bus24.in_ready, 1);
        chk({tag, " start sum"},  bus24.out_sum, 0);
        chk({tag, " start ovf16"}, bus16.out_ovf, 0);
        foreach (q[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                start    = poke;
                len      = 8'd3;
                tick;
                start = 1'b0;
                chk({tag, " gap vld"}, bus24.out_valid, 0);
                chk({tag, " gap rdy"}, bus16.in_ready, 1);
            end
            in_valid = 1'b1;
            product  = q[i];
            tick;
            in_valid = 1'b0;
            if (i < n - 1) chk({tag, " early vld"}, bus24.out_valid, 0);
        end
        chk({tag, " vld24"}, bus24.out_valid, 1);
        chk({tag, " vld16"}, bus16.out_valid, 1);
        chk({tag, " rdy"},   bus24.in_ready, 0);
        chk({tag, " sum24"}, bus24.out_sum, s24);
        chk({tag, " sum16"}, bus16.out_sum, s16);
        chk({tag, " ovf24"}, bus24.out_ovf, o24);
        chk({tag, " ovf16"}, bus16.out_ovf, o16);
        repeat (stall) begin
            start = poke;
            tick;
            start = 1'b0;
            chk({tag, " hold vld"},   bus24.out_valid, 1);
            chk({tag, " hold sum24"}, bus24.out_sum, s24);
            chk({tag, " hold sum16"}, bus16.out_sum, s16);
            chk({tag, " hold ovf16"}, bus16.out_ovf, o16);
        end
        out_ready = 1'b1;
        start     = poke;
        tick;
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, " post vld"},  bus24.out_valid, 0);
        chk({tag, " post busy"}, busy24, 0);
        tick;
        chk({tag, " idle busy"}, busy16, 0);
        chk({tag, " kept sum"},  bus24.out_sum, s24);
    endtask

    initial begin
        pq_t q;

        #2;
        chk_all_zero("reset");
        #10;
        rst_n = 1'b1;
        tick;

        q = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_job("len4", q, 0, 1'b0, 0);

        q = {};
        repeat (256) q.push_back(16'hFE01);
        run_job("max", q, 0, 1'b0, 0);

        q = '{16'hFFFF, 16'h0002};
        run_job("ovf", q, 0, 1'b0, 1);

        for (int j = 0; j < 4; j++) begin
            q = {};
            repeat ($urandom_range(20, 1)) q.push_back(16'($urandom));
            run_job("rand", q, 40, 1'b1, (j == 0) ? 5 : $urandom_range(3));
        end

        // abort with a beat presented alongside clear
        start = 1'b1;
        len   = 8'd5;
        tick;
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            product  = 16'($urandom);
            tick;
        end
        product = 16'd9;
        clear   = 1'b1;
        tick;
        clear = 1'b0;
        chk_all_zero("clear");
        repeat (6) begin
            tick;
            chk("clear no vld", bus24.out_valid, 0);
            chk("clear no rdy", bus16.in_ready, 0);
        end
        in_valid = 1'b0;

        // asynchronous reset in the middle of a job
        start = 1'b1;
        len   = 8'd5;
        tick;
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            product  = 16'($urandom_range(65535, 1));
            tick;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        tick;

        q = '{16'd7};
        run_job("after rst", q, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
